// File: rtl/iiitb_sipo.sv
// -----------------------------------------------------------------------------
// iiitb_sipo -- serial-in parallel-out deserializer (receive end of iiitb_piso)
//
// Samples one serial bit per clock with shift_en=1 and assembles WIDTH-bit
// words. A sync pulse marks bit 0 of each word. Each completed word is copied
// into a holding register and flagged with data_valid until the consumer
// acknowledges it. Lost words and misplaced syncs raise sticky error flags.
//
// Parameters
//   WIDTH      word width in bits (1..32)
//   MSB_FIRST  1: first received bit ends in data_out[WIDTH-1]
//              0: first received bit ends in data_out[0]
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   data_in     serial data bit, sampled when shift_en=1
//   shift_en    bit-valid strobe
//   sync        data_in is bit 0 of a new word (only with shift_en=1)
//   data_ack    consumer accepts data_out, clears data_valid
//   err_clr     clears overrun and frame_err
//   data_out    last completed word (holding register)
//   data_valid  data_out holds an unacknowledged word
//   busy        a word is partially received
//   overrun     sticky: an unacknowledged word was overwritten
//   frame_err   sticky: sync arrived mid-word
// -----------------------------------------------------------------------------
module iiitb_sipo #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             shift_en,
  input  logic             sync,
  input  logic             data_ack,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);
  // Count value at which the bit being sampled is the last one of the word.
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] r_data_out;
  logic             r_valid;
  logic             r_overrun;
  logic             r_frame_err;
  logic             w_complete;
  logic             w_frame_set;

  // Insert one bit into a partial word. Written with shifts rather than
  // part-selects so that WIDTH=1 needs no special case.
  function automatic logic [WIDTH-1:0] f_insert(input logic [WIDTH-1:0] base,
                                                input logic             b);
    logic [WIDTH-1:0] v;
    if (MSB_FIRST) begin
      v    = base << 1;
      v[0] = b;
    end else begin
      v          = base >> 1;
      v[WIDTH-1] = b;
    end
    return v;
  endfunction

  // Next-state logic. A sync always restarts the word from bit 0; the shift
  // register's old contents are dropped by inserting into an all-zero base.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_shift_nxt = r_shift;
    w_complete  = 1'b0;
    w_frame_set = 1'b0;

    case (r_state)
      IDLE: begin
        if (shift_en && sync) begin
          w_shift_nxt = f_insert('0, data_in);
          if (WIDTH == 1) begin
            // A one-bit word is complete as soon as it starts.
            w_complete  = 1'b1;
            w_count_nxt = '0;
          end else begin
            w_count_nxt = ONE_CNT;
            w_state_nxt = SHIFT;
          end
        end
      end

      SHIFT: begin
        if (shift_en) begin
          if (sync) begin
            // Premature sync: abandon the partial word, start a new one.
            w_frame_set = 1'b1;
            w_shift_nxt = f_insert('0, data_in);
            w_count_nxt = ONE_CNT;
          end else begin
            w_shift_nxt = f_insert(r_shift, data_in);
            if (r_count == LAST_CNT) begin
              w_complete  = 1'b1;
              w_count_nxt = '0;
              w_state_nxt = IDLE;
            end else begin
              w_count_nxt = r_count + ONE_CNT;
            end
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_shift     <= '0;
      r_data_out  <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_shift <= w_shift_nxt;

      // The holding register changes only on completion; newest word wins.
      if (w_complete) begin
        r_data_out <= w_shift_nxt;
      end

      // Completion outranks an ack on the same edge: the new word is valid.
      if (w_complete) begin
        r_valid <= 1'b1;
      end else if (data_ack) begin
        r_valid <= 1'b0;
      end

      // A word is lost only if the old one is still pending and not being
      // acknowledged on this very edge. Setting outranks clearing.
      if (w_complete && r_valid && !data_ack) begin
        r_overrun <= 1'b1;
      end else if (err_clr) begin
        r_overrun <= 1'b0;
      end

      if (w_frame_set) begin
        r_frame_err <= 1'b1;
      end else if (err_clr) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_valid;
  assign busy       = (r_state == SHIFT);
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_iiitb_sipo.sv
// -----------------------------------------------------------------------------
// tb_iiitb_sipo -- bench for iiitb_sipo (WIDTH=8).
//
// Two instances share all inputs: one MSB-first, one LSB-first. The stimulus
// process updates a reference model after every clock edge and queues the
// expected visible state; a monitor process pops one entry on each falling
// edge and compares it with both instances. The model keeps the bits of the
// current word in a queue and forms words arithmetically.
// -----------------------------------------------------------------------------
module tb_iiitb_sipo;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] out_m;
    logic [W-1:0] out_l;
    logic [3:0]   flags_m;  // {valid, busy, overrun, frame_err}
    logic [3:0]   flags_l;
  } snap_t;

  logic         clk;
  logic         rst;
  logic         data_in;
  logic         shift_en;
  logic         sync;
  logic         data_ack;
  logic         err_clr;

  logic [W-1:0] m_data_out;
  logic         m_valid, m_busy, m_overrun, m_frame_err;
  logic [W-1:0] l_data_out;
  logic         l_valid, l_busy, l_overrun, l_frame_err;

  iiitb_sipo #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .shift_en   (shift_en),
    .sync       (sync),
    .data_ack   (data_ack),
    .err_clr    (err_clr),
    .data_out   (m_data_out),
    .data_valid (m_valid),
    .busy       (m_busy),
    .overrun    (m_overrun),
    .frame_err  (m_frame_err)
  );

  iiitb_sipo #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .shift_en   (shift_en),
    .sync       (sync),
    .data_ack   (data_ack),
    .err_clr    (err_clr),
    .data_out   (l_data_out),
    .data_valid (l_valid),
    .busy       (l_busy),
    .overrun    (l_overrun),
    .frame_err  (l_frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------- model --
  bit           mdl_bits[$];  // bits of the word in progress, oldest first
  logic [W-1:0] mdl_out_m;
  logic [W-1:0] mdl_out_l;
  bit           mdl_valid;
  bit           mdl_ovr;
  bit           mdl_ferr;

  snap_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  function automatic snap_t expected();
    snap_t s;
    logic [3:0] f;
    f = {mdl_valid, mdl_bits.size() != 0, mdl_ovr, mdl_ferr};
    s = '{out_m: mdl_out_m, out_l: mdl_out_l, flags_m: f, flags_l: f};
    return s;
  endfunction

  task automatic model_reset();
    mdl_bits.delete();
    mdl_out_m = '0;
    mdl_out_l = '0;
    mdl_valid = 1'b0;
    mdl_ovr   = 1'b0;
    mdl_ferr  = 1'b0;
  endtask

  // One rising edge of behaviour, using the inputs that were present at it.
  task automatic model_edge();
    bit done;
    bit fset;
    logic [W-1:0] wm;
    logic [W-1:0] wl;
    done = 1'b0;
    fset = 1'b0;
    wm   = '0;
    wl   = '0;
    if (!rst) begin
      model_reset();
    end else begin
      if (shift_en) begin
        if (sync) begin
          if (mdl_bits.size() != 0) fset = 1'b1;
          mdl_bits.delete();
          mdl_bits.push_back(data_in);
        end else if (mdl_bits.size() != 0) begin
          mdl_bits.push_back(data_in);
        end
        if (mdl_bits.size() == W) begin
          done = 1'b1;
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = mdl_bits[i];
            wl[i]     = mdl_bits[i];
          end
          mdl_bits.delete();
        end
      end
      if (done && mdl_valid && !data_ack) mdl_ovr = 1'b1;
      else if (err_clr)                   mdl_ovr = 1'b0;
      if (fset)         mdl_ferr = 1'b1;
      else if (err_clr) mdl_ferr = 1'b0;
      if (done) begin
        mdl_valid = 1'b1;
        mdl_out_m = wm;
        mdl_out_l = wl;
      end else if (data_ack) begin
        mdl_valid = 1'b0;
      end
    end
  endtask

  // ------------------------------------------------------------- stimulus --
  task automatic step(input bit r, input bit d, input bit se, input bit sy,
                      input bit ak, input bit ec);
    rst      = r;
    data_in  = d;
    shift_en = se;
    sync     = sy;
    data_ack = ak;
    err_clr  = ec;
    @(posedge clk);
    model_edge();
    exp_q.push_back(expected());
    #1;
  endtask

  task automatic idle(input int n, input bit ak, input bit ec);
    for (int i = 0; i < n; i++) step(1'b1, 1'($urandom), 1'b0, 1'($urandom), ak, ec);
  endtask

  // Send w[7] first. Optional shift_en gap after gap_after bits.
  task automatic send_word(input logic [W-1:0] w, input int gap_after,
                           input int gap_len, input bit ack_first,
                           input bit ack_last);
    for (int i = 0; i < W; i++) begin
      step(1'b1, w[W-1-i], 1'b1, i == 0,
           (i == 0 && ack_first) || (i == W-1 && ack_last), 1'b0);
      if (i + 1 == gap_after)
        for (int g = 0; g < gap_len; g++)
          step(1'b1, 1'($urandom), 1'b0, 1'($urandom), 1'b0, 1'b0);
    end
  endtask

  // Reset between clock edges; the expectation for the coming falling edge
  // becomes the cleared state, which only an asynchronous reset can show.
  task automatic async_reset();
    rst = 1'b0;
    #1;
    model_reset();
    void'(exp_q.pop_back());
    exp_q.push_back(expected());
  endtask

  // -------------------------------------------------------------- monitor --
  initial begin
    snap_t e;
    snap_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{out_m: m_data_out, out_l: l_data_out,
              flags_m: {m_valid, m_busy, m_overrun, m_frame_err},
              flags_l: {l_valid, l_busy, l_overrun, l_frame_err}};
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL outputs @%0t: got out_m=%h out_l=%h flags_m=%b flags_l=%b, want out_m=%h out_l=%h flags=%b (v,b,ovr,ferr)",
                   $time, a.out_m, a.out_l, a.flags_m, a.flags_l,
                   e.out_m, e.out_l, e.flags_m);
        end
      end
    end
  end

  // ----------------------------------------------------------------- main --
  initial begin
    // Reset held with random inputs.
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    // Bits without sync are ignored while idle.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Basic word, then ack; data_out must hold after the ack.
    send_word(8'h0F, 0, 0, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    idle(2, 1'b0, 1'b0);

    // Gapped word, then back-to-back word acked with its first bit.
    send_word(8'hFF, 4, 3, 1'b0, 1'b0);
    send_word(8'h00, 0, 0, 1'b1, 1'b0);
    idle(1, 1'b1, 1'b0);

    // Overrun, then clear it.
    send_word(8'h0F, 0, 0, 1'b0, 1'b0);
    send_word(8'hA5, 0, 0, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b1);
    // Ack on the completing edge while the previous word is pending.
    send_word(8'h5A, 0, 0, 1'b0, 1'b1);
    idle(1, 1'b1, 1'b0);

    // Framing error: 4 bits, then a new sync starting 8'h3C.
    for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom), 1'b1, i == 0, 1'b0, 1'b0);
    send_word(8'h3C, 0, 0, 1'b0, 1'b0);
    idle(2, 1'b1, 1'b1);

    // Reset mid-word with a pending word, then a fresh word.
    send_word(8'h96, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b1, i == 0, 1'b0, 1'b0);
    async_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b0);
    send_word(8'hC3, 0, 0, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bit se;
      se = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 399) != 0, 1'($urandom), se,
           se && ($urandom_range(0, 11) == 0),
           $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
    end
    idle(2, 1'b0, 1'b0);

    // Every queued expectation must have been consumed by the monitor.
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iiitb_sipo.md
# iiitb_sipo

Serial-in parallel-out deserializer, the receive end of the iiitb_piso serial link. It samples one bit per enabled clock and assembles WIDTH-bit words, with a frame-sync input aligning each word boundary. Each completed word is presented on a stable parallel holding register with a valid/ack handshake and sticky overrun and framing error flags. It sits between the serial link and a parallel consumer.

## Interface

- WIDTH, 8, word width in bits; legal range 1–32.
- MSB_FIRST, 1, 1: first received bit lands in data_out[WIDTH-1]; 0: first bit lands in data_out[0].

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- data_in  in  1  serial data bit; sampled only when shift_en=1.
- shift_en  in  1  bit-valid strobe; one bit is consumed per clock with shift_en=1.
- sync  in  1  marks data_in as bit 0 of a new word; honoured only when shift_en=1.
- data_ack  in  1  consumer accepts data_out; clears data_valid.
- err_clr  in  1  clears overrun and frame_err.
- data_out  out  WIDTH  last completed word (holding register).
- data_valid  out  1  high while data_out holds an unacknowledged word.
- busy  out  1  high while a word is partially received.
- overrun  out  1  sticky: an unacknowledged word was overwritten.
- frame_err  out  1  sticky: sync arrived mid-word.

## Operation

- Reset (rst=0, any time, asynchronous): state IDLE, bit counter 0, shift register 0, data_out 0, data_valid 0, busy 0, overrun 0, frame_err 0. A partial word is discarded.
- FSM states: IDLE, SHIFT.
- IDLE: shift_en=1 with sync=0 is ignored. shift_en=1 with sync=1 captures data_in as bit 0 and sets count to 1.
  - WIDTH=1: the word completes on that edge and the FSM stays in IDLE.
  - Otherwise: go to SHIFT.
- SHIFT, shift_en=0: hold all state.
- SHIFT, shift_en=1, sync=0: capture data_in as the next bit and increment count.
  - When the captured bit is bit WIDTH-1, the word completes and the FSM returns to IDLE with count 0.
- SHIFT, shift_en=1, sync=1: discard the partial word, set frame_err, capture data_in as bit 0 of a new word, set count to 1 and stay in SHIFT.
- Bit placement:
  - MSB_FIRST=1: shift left, new bit enters at the LSB. After WIDTH bits, the first bit received is in bit WIDTH-1.
  - MSB_FIRST=0: shift right, new bit enters at the MSB. After WIDTH bits, the first bit received is in bit 0.
- Word completion, on the same edge that samples the last bit:
  - data_out gets the full word, including the bit just sampled.
  - data_valid is set to 1.
  - If data_valid was already 1 and data_ack=0 in that cycle, overrun is set and data_out is still overwritten (newest word wins).
- Handshake:
  - data_ack=1 while data_valid=1 clears data_valid on that edge, unless a completion occurs on the same edge.
  - Completion and ack on the same edge: data_valid stays 1, data_out takes the new word, no overrun.
  - data_ack while data_valid=0 has no effect.
- busy = (state==SHIFT); it is registered.
- err_clr=1 clears both sticky flags on the edge.
  - If a set condition occurs on the same edge, the set wins.
- The bit counter width is clog2(WIDTH+1). Count never exceeds WIDTH-1 in SHIFT.

## Timing

- Latency: data_out and data_valid update on the rising edge that samples the last bit. They are visible one cycle after the last bit is presented.
- Back-to-back words need no idle cycle: sync with bit 0 of the next word may arrive on the cycle immediately after the last bit.
- data_out is stable from completion until the next completion, independent of ack.
- data_valid is not combinationally dependent on data_ack; all outputs are registered.
- Minimum word period is WIDTH clocks with continuous shift_en.
- Throughput is limited only by the consumer's ack; no backpressure is provided to the serial side.

## Test plan

- Reset: hold rst=0 with random inputs → all outputs 0. Release rst, then drive shift_en=1, sync=0, data_in=1 for 10 clocks → busy stays 0, data_valid stays 0.
- Basic word, WIDTH=8, MSB_FIRST=1: sync on the first bit, serial 0,0,0,0,1,1,1,1 → data_out=8'h0F and data_valid=1 after the 8th edge. Ack next cycle → data_valid=0 and data_out still 8'h0F.
  - Repeat with MSB_FIRST=0 → data_out=8'hF0.
- Gapped and back-to-back: send 8'hFF with shift_en dropped for 3 cycles mid-word → data_out=8'hFF. Immediately send 8'h00 with acks each word → two valid words, no overrun.
- Overrun: send 8'h0F without ack, then 8'hA5 without ack → data_out=8'hA5, overrun=1. Pulse err_clr → overrun=0.
  - Ack on the same edge as completion → no overrun.
- Framing error: after 4 bits of a word, assert sync and send 8'h3C → frame_err=1, data_out=8'h3C, only one data_valid rise.
- Reset mid-operation: assert rst after 5 bits with data_valid=1 → immediate async clear of all outputs. A fresh word after release → correct data_out.
